// File: rtl/lsu_stage_if.sv
// Handshake and data-SRAM bundle between EX, the load/store stage and MEM.
// master = the side driving EX/MEM controls (upstream pipeline), slave = lsu_stage.
interface lsu_stage_if;
    logic         es_to_ls_valid;
    logic [105:0] es_to_ls_bus;
    logic         ls_allowin;
    logic         ms_allowin;
    logic         ls_to_ms_valid;
    logic [75:0]  ls_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         flush;
    logic         ls_ex;
    logic [31:0]  ls_badvaddr;

    modport master (
        output es_to_ls_valid, es_to_ls_bus, ms_allowin, flush,
        input  ls_allowin, ls_to_ms_valid, ls_to_ms_bus, data_sram_en,
               data_sram_wen, data_sram_addr, data_sram_wdata, ls_ex, ls_badvaddr
    );

    modport slave (
        input  es_to_ls_valid, es_to_ls_bus, ms_allowin, flush,
        output ls_allowin, ls_to_ms_valid, ls_to_ms_bus, data_sram_en,
               data_sram_wen, data_sram_addr, data_sram_wdata, ls_ex, ls_badvaddr
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: holds one EX instruction and issues its data-SRAM request at handoff.
// Optional LSU_ALIGN_CHECK_EN raises an address error on misaligned halfword/word accesses.
module lsu_stage (
    input  logic        clk,
    input  logic        resetn,
    lsu_stage_if.slave  lsu
);

    logic         ls_valid;
    logic [105:0] ls_bus;
    logic         ls_allowin;

    logic [3:0]   mem_op;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  addr;
    logic [31:0]  st_data;
    logic [31:0]  pc;

    logic         is_load;
    logic         is_store;
    logic         is_half;
    logic         is_word;
    logic         ls_ex;
    logic [1:0]   eff_off;
    logic [3:0]   wen;
    logic [31:0]  wdata;

    assign {mem_op, gr_we, dest, addr, st_data, pc} = ls_bus;

    assign ls_allowin = !ls_valid || lsu.ms_allowin;

    // flush wins over a simultaneous accept; the bus register still follows the accept rule
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ls_valid <= 1'b0;
            ls_bus   <= '0;
        end else begin
            if (lsu.flush)
                ls_valid <= 1'b0;
            else if (ls_allowin)
                ls_valid <= lsu.es_to_ls_valid;
            if (lsu.es_to_ls_valid && ls_allowin)
                ls_bus <= lsu.es_to_ls_bus;
        end
    end

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_op)
            4'd1, 4'd2: is_load = 1'b1;
            4'd3, 4'd4: begin is_load = 1'b1; is_half = 1'b1; end
            4'd5:       begin is_load = 1'b1; is_word = 1'b1; end
            4'd8:       is_store = 1'b1;
            4'd9:       begin is_store = 1'b1; is_half = 1'b1; end
            4'd10:      begin is_store = 1'b1; is_word = 1'b1; end
            default:    ;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign ls_ex      = ls_valid && misaligned;
    assign eff_off    = addr[1:0];
`else
    // without the check, misaligned accesses silently round down to their natural boundary
    assign ls_ex   = 1'b0;
    assign eff_off = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif

    always_comb begin
        wen   = 4'b0000;
        wdata = '0;
        case (mem_op)
            4'd8: begin
                wen   = 4'b0001 << eff_off;
                wdata = {4{st_data[7:0]}};
            end
            4'd9: begin
                wen   = 4'b0011 << eff_off;
                wdata = {2{st_data[15:0]}};
            end
            4'd10: begin
                wen   = 4'b1111;
                wdata = st_data;
            end
            default: ;
        endcase
    end

    assign lsu.ls_allowin      = ls_allowin;
    assign lsu.ls_to_ms_valid  = ls_valid && !lsu.flush;
    assign lsu.data_sram_en    = ls_valid && (is_load || is_store) && lsu.ms_allowin
                                 && !lsu.flush && !ls_ex;
    assign lsu.data_sram_wen   = wen;
    assign lsu.data_sram_addr  = {addr[31:2], 2'b00};
    assign lsu.data_sram_wdata = wdata;
    assign lsu.ls_ex           = ls_ex;
    assign lsu.ls_badvaddr     = ls_ex ? addr : 32'd0;
    assign lsu.ls_to_ms_bus    = {(is_load ? mem_op[2:0] : 3'd0), eff_off, is_load,
                                  gr_we && !ls_ex, dest, addr, pc};

endmodule

// File: tb/tb_lsu_stage.sv
// Directed and random checks of lsu_stage against a byte-level behavioural model.
module tb_lsu_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    lsu_stage_if bus_if ();
    lsu_stage dut (.clk(clk), .resetn(resetn), .lsu(bus_if));

    int total = 0;
    int bad   = 0;

    logic         mv;
    logic [105:0] mb;

    function automatic logic [105:0] mk(input logic [3:0] op, input logic gw, input logic [4:0] dst,
                                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc);
        return {op, gw, dst, a, sd, pc};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int unsigned op, size, off, a_mod;
        logic [31:0] a, sd, exp_wdata;
        logic        ld, st, ex, en;
        logic [3:0]  exp_wen;
        logic [75:0] exp_bus;
        op = mb[105:102];
        a  = mb[95:64];
        sd = mb[63:32];
        ld = (op >= 1) && (op <= 5);
        st = (op >= 8) && (op <= 10);
        case (op)
            3, 4, 9: size = 2;
            5, 10:   size = 4;
            default: size = 1;
        endcase
        a_mod = a % 4;
`ifdef LSU_ALIGN_CHECK_EN
        ex  = mv && (ld || st) && ((a % size) != 0);
        off = a_mod;
`else
        ex  = 1'b0;
        off = (a_mod / size) * size;
`endif
        en = mv && (ld || st) && bus_if.ms_allowin && !bus_if.flush && !ex;
        exp_wen = st ? 4'((((1 << size) - 1) << off) & 15) : 4'd0;
        exp_wdata = (size == 1) ? sd[7:0] * 32'h01010101 :
                    (size == 2) ? sd[15:0] * 32'h00010001 : sd;
        exp_bus = {(ld ? 3'(op) : 3'd0), 2'(off), ld, mb[101] && !ex, mb[100:96], a, mb[31:0]};
        check({tag, ".allowin"}, bus_if.ls_allowin, !mv || bus_if.ms_allowin);
        check({tag, ".to_ms_valid"}, bus_if.ls_to_ms_valid, mv && !bus_if.flush);
        check({tag, ".en"}, bus_if.data_sram_en, en);
        check({tag, ".addr"}, bus_if.data_sram_addr, a & 32'hFFFF_FFFC);
        check({tag, ".wen"}, bus_if.data_sram_wen, exp_wen);
        if (st && en) check({tag, ".wdata"}, bus_if.data_sram_wdata, exp_wdata);
        check({tag, ".bus"}, bus_if.ls_to_ms_bus, exp_bus);
        check({tag, ".ex"}, bus_if.ls_ex, ex);
        check({tag, ".badv"}, bus_if.ls_badvaddr, ex ? a : 32'd0);
    endtask

    task automatic drive(input logic v, input logic [105:0] b, input logic ms, input logic fl);
        bus_if.es_to_ls_valid = v;
        bus_if.es_to_ls_bus   = b;
        bus_if.ms_allowin     = ms;
        bus_if.flush          = fl;
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic tick();
        logic allow;
        @(posedge clk);
        allow = !mv || bus_if.ms_allowin;
        if (bus_if.es_to_ls_valid && allow) mb = bus_if.es_to_ls_bus;
        if (bus_if.flush) mv = 1'b0;
        else if (allow)   mv = bus_if.es_to_ls_valid;
        #1;
    endtask

    initial begin
        logic [3:0] op;
        mv = 1'b0;
        mb = '0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #12;
        check_model("reset");
        check("reset.allowin_const", bus_if.ls_allowin, 1'b1);
        resetn = 1'b1;
        tick();

        // SW aligned
        drive(1'b1, mk(4'd10, 1'b0, 5'd0, 32'h100, 32'h11223344, 32'h1000), 1'b1, 1'b0);
        settle("sw_issue");
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        settle("sw_held");
        check("sw.en", bus_if.data_sram_en, 1'b1);
        check("sw.wen", bus_if.data_sram_wen, 4'b1111);
        check("sw.addr", bus_if.data_sram_addr, 32'h100);
        check("sw.wdata", bus_if.data_sram_wdata, 32'h11223344);
        tick();
        settle("sw_after");
        check("sw.one_cycle", bus_if.data_sram_en, 1'b0);

        // SB to top byte
        drive(1'b1, mk(4'd8, 1'b0, 5'd0, 32'h103, 32'h000000AB, 32'h1004), 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        settle("sb_held");
        check("sb.wen", bus_if.data_sram_wen, 4'b1000);
        check("sb.wdata", bus_if.data_sram_wdata, 32'hABABABAB);
        check("sb.res_from_mem", bus_if.ls_to_ms_bus[70], 1'b0);
        tick();

        // LHU stalled by MEM for three cycles; a new EX instruction must not overwrite it
        drive(1'b1, mk(4'd4, 1'b1, 5'd7, 32'h202, 32'h0, 32'h1008), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(4'd5, 1'b1, 5'd9, 32'h400, 32'h0, 32'h100C), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle("lhu_stall");
            check("lhu.stall_en", bus_if.data_sram_en, 1'b0);
            check("lhu.stall_allowin", bus_if.ls_allowin, 1'b0);
            check("lhu.stall_pc", bus_if.ls_to_ms_bus[31:0], 32'h1008);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        settle("lhu_go");
        check("lhu.en", bus_if.data_sram_en, 1'b1);
        check("lhu.ld_type", bus_if.ls_to_ms_bus[75:73], 3'd4);
        check("lhu.byte_off", bus_if.ls_to_ms_bus[72:71], 2'd2);
        tick();

        // LW misaligned
        drive(1'b1, mk(4'd5, 1'b1, 5'd3, 32'h301, 32'h0, 32'h1010), 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        settle("lw_mis");
`ifdef LSU_ALIGN_CHECK_EN
        check("lw_mis.en", bus_if.data_sram_en, 1'b0);
        check("lw_mis.ex", bus_if.ls_ex, 1'b1);
        check("lw_mis.badv", bus_if.ls_badvaddr, 32'h301);
        check("lw_mis.gr_we", bus_if.ls_to_ms_bus[69], 1'b0);
`else
        check("lw_mis.en", bus_if.data_sram_en, 1'b1);
        check("lw_mis.addr", bus_if.data_sram_addr, 32'h300);
        check("lw_mis.ex", bus_if.ls_ex, 1'b0);
`endif
        tick();

        // flush on SB with a new instruction arriving
        drive(1'b1, mk(4'd8, 1'b0, 5'd0, 32'h500, 32'h5A, 32'h1014), 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(4'd5, 1'b1, 5'd4, 32'h600, 32'h0, 32'h1018), 1'b1, 1'b1);
        settle("flush");
        check("flush.en", bus_if.data_sram_en, 1'b0);
        check("flush.to_ms_valid", bus_if.ls_to_ms_valid, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        settle("flush_after");
        check("flush.ls_valid_cleared", bus_if.ls_allowin, 1'b1);
        tick();

        // async reset while a SW request is live
        drive(1'b1, mk(4'd10, 1'b1, 5'd1, 32'h700, 32'hCAFEF00D, 32'h101C), 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        settle("rst_pre");
        check("rst_pre.en", bus_if.data_sram_en, 1'b1);
        #2 resetn = 1'b0;
        #1;
        mv = 1'b0;
        mb = '0;
        check("rst_mid.en", bus_if.data_sram_en, 1'b0);
        check("rst_mid.to_ms_valid", bus_if.ls_to_ms_valid, 1'b0);
        check("rst_mid.allowin", bus_if.ls_allowin, 1'b1);
        check_model("rst_mid");
        @(posedge clk);
        #1 resetn = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            drive(($urandom % 4) != 0,
                  mk(op, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom),
                  ($urandom % 4) != 0, ($urandom % 10) == 0);
            settle("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
